flag_branch_unit: RTL and testbench

- Consumer side of the ALU result path.
- Latches `alu_flags_t` from the ALU into an architectural status register.
- Evaluates branch conditions against those flags and returns a registered branch decision plus target PC to fetch over a valid/ready handshake.
- Sits between the execute stage (ALU) and the fetch/PC logic.

---
 rtl/defs_pkg.sv | 50 +++++
 rtl/flag_stack.sv | 56 +++++
 rtl/flag_branch_unit.sv | 104 ++++++++++
 tb/tb_flag_branch_unit.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/defs_pkg.sv
// Shared execute-stage types: ALU flag word, branch condition codes and
// the condition evaluator used by the branch unit.
package defs_pkg;

   // Flags produced by the ALU; zero is the MSB of the packed word.
   typedef struct packed {
      logic zero;
      logic negative;
      logic carry;
      logic overflow;
   } alu_flags_t;

   // Branch condition codes; 12-15 are reserved and never taken.
   typedef enum logic [3:0] {
      COND_AL  = 4'd0,
      COND_EQ  = 4'd1,
      COND_NE  = 4'd2,
      COND_LT  = 4'd3,
      COND_GE  = 4'd4,
      COND_LTU = 4'd5,
      COND_GEU = 4'd6,
      COND_MI  = 4'd7,
      COND_PL  = 4'd8,
      COND_VS  = 4'd9,
      COND_VC  = 4'd10,
      COND_NV  = 4'd11
   } cond_t;

   // Returns 1 when the condition holds for the given flags.
   function automatic bit cond_eval(input cond_t cond, input alu_flags_t flags);
      bit taken;
      taken = 1'b0;
      case (cond)
         COND_AL:  taken = 1'b1;
         COND_EQ:  taken = flags.zero;
         COND_NE:  taken = !flags.zero;
         COND_LT:  taken = flags.negative ^ flags.overflow;
         COND_GE:  taken = !(flags.negative ^ flags.overflow);
         COND_LTU: taken = flags.carry;
         COND_GEU: taken = !flags.carry;
         COND_MI:  taken = flags.negative;
         COND_PL:  taken = !flags.negative;
         COND_VS:  taken = flags.overflow;
         COND_VC:  taken = !flags.overflow;
         default:  taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/flag_stack.sv
// LIFO of saved status flags for interrupt entry/return.
// Illegal operations (push when full, pop when empty, push with pop) are
// dropped and reported with a one-cycle err pulse.
module flag_stack
   import defs_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic       pop,
   input  alu_flags_t push_data,
   output logic       pop_ok_c,
   output alu_flags_t pop_data_c,
   output logic       empty_c,
   output logic       full_c,
   output logic       err
);

   localparam int unsigned PTR_W = $clog2(DEPTH + 1);
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PTR_W-1:0] ptr;
   alu_flags_t       mem [DEPTH];
   logic             push_ok_c;

   assign empty_c    = (ptr == '0);
   assign full_c     = (ptr == PTR_W'(DEPTH));
   assign push_ok_c  = push && !pop && !full_c;
   assign pop_ok_c   = pop && !push && !empty_c;
   assign pop_data_c = mem[IDX_W'(ptr - PTR_W'(1))];

   // Pointer and error pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
         err <= 1'b0;
      end else begin
         err <= (push && pop) || (push && full_c) || (pop && empty_c);
         if (push_ok_c) begin
            ptr <= ptr + PTR_W'(1);
         end else if (pop_ok_c) begin
            ptr <= ptr - PTR_W'(1);
         end
      end
   end

   // Entry storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push_ok_c) begin
         mem[IDX_W'(ptr)] <= push_data;
      end
   end

endmodule

// File: rtl/flag_branch_unit.sv
// Architectural status register plus branch resolver. Branch requests are
// evaluated against the (forwarded) flags and returned one cycle later
// through a one-entry output register with valid/ready flow control.
// Define FLAG_STACK_EN to add the interrupt flag save/restore stack.
module flag_branch_unit
   import defs_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned STACK_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  alu_flags_t       flags_in,
   input  logic             flags_we,
   output alu_flags_t       flags_q,
   input  logic             br_valid,
   output logic             br_ready,
   input  cond_t            br_cond,
   input  logic [WIDTH-1:0] br_pc,
   input  logic [WIDTH-1:0] br_offset,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_taken,
   output logic [WIDTH-1:0] res_pc,
   input  logic             flag_push,
   input  logic             flag_pop,
   output logic             stack_empty,
   output logic             stack_full,
   output logic             stack_err
);

   if (STACK_DEPTH < 1) begin : g_depth_check
      $error("flag_branch_unit: STACK_DEPTH must be at least 1");
   end

   logic             accept_c;
   logic             taken_c;
   alu_flags_t       eff_flags_c;
   logic [WIDTH-1:0] target_c;
   logic             restore_c;
   alu_flags_t       restore_flags_c;

`ifdef FLAG_STACK_EN
   flag_stack #(
      .DEPTH (STACK_DEPTH)
   ) u_flag_stack (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (flag_push),
      .pop        (flag_pop),
      .push_data  (flags_q),
      .pop_ok_c   (restore_c),
      .pop_data_c (restore_flags_c),
      .empty_c    (stack_empty),
      .full_c     (stack_full),
      .err        (stack_err)
   );
`else
   logic stack_unused;
   assign stack_unused    = flag_push ^ flag_pop;
   assign restore_c       = 1'b0;
   assign restore_flags_c = '0;
   assign stack_empty     = 1'b1;
   assign stack_full      = 1'b0;
   assign stack_err       = 1'b0;
`endif

   // Handshake, flag forwarding and target selection. Offset and PC share a
   // width, so plain modulo addition already sign-extends the offset.
   always_comb begin
      br_ready    = !res_valid || res_ready;
      accept_c    = br_valid && br_ready;
      eff_flags_c = flags_we ? flags_in : flags_q;
      taken_c     = cond_eval(br_cond, eff_flags_c);
      target_c    = taken_c ? (br_pc + br_offset) : (br_pc + WIDTH'(1));
   end

   // Status register: stack restore beats an ALU write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= '0;
      end else if (restore_c) begin
         flags_q <= restore_flags_c;
      end else if (flags_we) begin
         flags_q <= flags_in;
      end
   end

   // One-entry result register; holds while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_taken <= 1'b0;
         res_pc    <= '0;
      end else if (accept_c) begin
         res_valid <= 1'b1;
         res_taken <= taken_c;
         res_pc    <= target_c;
      end else if (res_ready) begin
         res_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Randomised and directed bench for flag_branch_unit against a behavioural
// model. Stack scenarios are exercised when FLAG_STACK_EN is defined.
`timescale 1ns/1ps
module tb_flag_branch_unit;
   import defs_pkg::*;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 4;
   localparam int          MODV  = 1 << WIDTH;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   alu_flags_t       flags_in;
   logic             flags_we;
   alu_flags_t       flags_q;
   logic             br_valid;
   logic             br_ready;
   cond_t            br_cond;
   logic [WIDTH-1:0] br_pc;
   logic [WIDTH-1:0] br_offset;
   logic             res_valid;
   logic             res_ready;
   logic             res_taken;
   logic [WIDTH-1:0] res_pc;
   logic             flag_push;
   logic             flag_pop;
   logic             stack_empty;
   logic             stack_full;
   logic             stack_err;

   flag_branch_unit #(
      .WIDTH       (WIDTH),
      .STACK_DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flags_in    (flags_in),
      .flags_we    (flags_we),
      .flags_q     (flags_q),
      .br_valid    (br_valid),
      .br_ready    (br_ready),
      .br_cond     (br_cond),
      .br_pc       (br_pc),
      .br_offset   (br_offset),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_taken   (res_taken),
      .res_pc      (res_pc),
      .flag_push   (flag_push),
      .flag_pop    (flag_pop),
      .stack_empty (stack_empty),
      .stack_full  (stack_full),
      .stack_err   (stack_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Model state: flags as {Z,N,C,V}, result register, stack as a queue.
   logic [3:0] m_flags;
   bit         m_valid;
   bit         m_taken;
   int         m_pc;
   logic [3:0] m_stack[$];
   bit         m_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit ref_cond(input int code, input logic [3:0] f);
      bit z = f[3];
      bit n = f[2];
      bit c = f[1];
      bit v = f[0];
      bit slt = (n != v);
      case (code)
         0:       return 1'b1;
         1:       return z;
         2:       return !z;
         3:       return slt;
         4:       return !slt;
         5:       return c;
         6:       return !c;
         7:       return n;
         8:       return !n;
         9:       return v;
         10:      return !v;
         default: return 1'b0;
      endcase
   endfunction

   task automatic reset_model();
      m_flags = 4'b0000;
      m_valid = 1'b0;
      m_taken = 1'b0;
      m_pc    = 0;
      m_stack.delete();
      m_err   = 1'b0;
   endtask

   task automatic drive_idle();
      flags_we  = 1'b0;
      flags_in  = '0;
      br_valid  = 1'b0;
      br_cond   = COND_AL;
      br_pc     = '0;
      br_offset = '0;
      res_ready = 1'b1;
      flag_push = 1'b0;
      flag_pop  = 1'b0;
   endtask

   // One clock: drive, check current outputs against the model, advance model.
   task automatic step(input bit we, input logic [3:0] fin, input bit bv, input int cond,
                       input int pc, input int off, input bit rr, input bit push, input bit pop);
      bit         acc;
      bit         tk;
      bit         e_err;
      bit         do_push;
      bit         do_pop;
      logic [3:0] eff;
      logic [3:0] rflags;
      int         o;
      int         tgt;
      @(negedge clk);
      flags_we  = we;
      flags_in  = alu_flags_t'(fin);
      br_valid  = bv;
      br_cond   = cond_t'(4'(cond));
      br_pc     = WIDTH'(pc);
      br_offset = WIDTH'(off);
      res_ready = rr;
      flag_push = push;
      flag_pop  = pop;
      #1;
      check("br_ready", 32'(br_ready), 32'(!m_valid || rr));
      check("res_valid", 32'(res_valid), 32'(m_valid));
      check("res_taken", 32'(res_taken), 32'(m_taken));
      check("res_pc", 32'(res_pc), 32'(m_pc));
      check("flags_q", 32'(flags_q), 32'(m_flags));
      check("stack_err", 32'(stack_err), 32'(m_err));
`ifdef FLAG_STACK_EN
      check("stack_empty", 32'(stack_empty), 32'(m_stack.size() == 0));
      check("stack_full", 32'(stack_full), 32'(m_stack.size() == DEPTH));
`else
      check("stack_empty", 32'(stack_empty), 32'd1);
      check("stack_full", 32'(stack_full), 32'd0);
`endif
      acc = bv && (!m_valid || rr);
      eff = we ? fin : m_flags;
      tk  = ref_cond(cond, eff);
      o   = off % MODV;
      if (o >= MODV / 2) o = o - MODV;
      tgt = tk ? (pc + o) : (pc + 1);
      tgt = ((tgt % MODV) + MODV) % MODV;
      e_err   = 1'b0;
      do_push = 1'b0;
      do_pop  = 1'b0;
      rflags  = 4'b0000;
`ifdef FLAG_STACK_EN
      if (push && pop) begin
         e_err = 1'b1;
      end else if (push) begin
         if (m_stack.size() == DEPTH) e_err = 1'b1;
         else do_push = 1'b1;
      end else if (pop) begin
         if (m_stack.size() == 0) e_err = 1'b1;
         else begin
            do_pop = 1'b1;
            rflags = m_stack[m_stack.size() - 1];
         end
      end
`endif
      @(posedge clk);
      #1;
      if (do_push) m_stack.push_back(m_flags);
      if (do_pop) void'(m_stack.pop_back());
      if (do_pop) m_flags = rflags;
      else if (we) m_flags = fin;
      m_err = e_err;
      if (acc) begin
         m_valid = 1'b1;
         m_taken = tk;
         m_pc    = tgt;
      end else if (rr) begin
         m_valid = 1'b0;
      end
   endtask

   initial begin
      drive_idle();
      reset_model();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_taken", 32'(res_taken), 32'd0);
      check("rst_res_pc", 32'(res_pc), 32'd0);
      check("rst_flags_q", 32'(flags_q), 32'd0);
      check("rst_stack_empty", 32'(stack_empty), 32'd1);
      check("rst_stack_full", 32'(stack_full), 32'd0);
      check("rst_stack_err", 32'(stack_err), 32'd0);

      // Same-cycle flag write forwarded into an EQ branch.
      step(1, 4'b1000, 1, 1, 'h10, 'hFC, 1, 0, 0);
      check("fwd_valid", 32'(res_valid), 32'd1);
      check("fwd_taken", 32'(res_taken), 32'd1);
      check("fwd_pc", 32'(res_pc), 32'h0C);

      // Not-taken fall-through wraps to zero.
      step(1, 4'b0000, 0, 0, 0, 0, 1, 0, 0);
      step(0, 4'b0000, 1, 5, 'hFF, 'h33, 1, 0, 0);
      check("ntw_taken", 32'(res_taken), 32'd0);
      check("ntw_pc", 32'(res_pc), 32'h00);

      // Taken target wraps.
      step(0, 4'b0000, 1, 6, 'hF0, 'h20, 1, 0, 0);
      check("tw_taken", 32'(res_taken), 32'd1);
      check("tw_pc", 32'(res_pc), 32'h10);

      // Backpressure holds the result; then one handshake per cycle.
      repeat (3) step(0, 4'b0000, 1, 0, 'h40, 'h05, 0, 0, 0);
      check("bp_valid", 32'(res_valid), 32'd1);
      check("bp_pc", 32'(res_pc), 32'h10);
      for (int i = 0; i < 4; i++) step(0, 4'b0000, 1, 0, 'h40 + i, 'h05, 1, 0, 0);
      check("bp_last_pc", 32'(res_pc), 32'h48);

      // Signed compare with N=V, plus a reserved code.
      step(1, 4'b0101, 0, 0, 0, 0, 1, 0, 0);
      step(0, 4'b0000, 1, 3, 'h20, 'h04, 1, 0, 0);
      check("lt_taken", 32'(res_taken), 32'd0);
      check("lt_pc", 32'(res_pc), 32'h21);
      step(0, 4'b0000, 1, 4, 'h20, 'h04, 1, 0, 0);
      check("ge_taken", 32'(res_taken), 32'd1);
      check("ge_pc", 32'(res_pc), 32'h24);
      step(0, 4'b0000, 1, 13, 'h20, 'h04, 1, 0, 0);
      check("rsv_taken", 32'(res_taken), 32'd0);

`ifdef FLAG_STACK_EN
      // Four pushes, each saving the pre-write flags.
      for (int k = 0; k < 4; k++) step(1, 4'(k + 3), 0, 0, 0, 0, 1, 1, 0);
      check("stk_full", 32'(stack_full), 32'd1);
      step(1, 4'b1111, 0, 0, 0, 0, 1, 1, 0);
      check("stk_ovf_err", 32'(stack_err), 32'd1);
      check("stk_ovf_full", 32'(stack_full), 32'd1);
      step(1, 4'b0100, 0, 0, 0, 0, 1, 0, 0);
      check("stk_err_clear", 32'(stack_err), 32'd0);
      step(1, 4'b1010, 0, 0, 0, 0, 1, 0, 1);
      check("stk_pop_top", 32'(flags_q), 32'h5);
      repeat (3) step(0, 4'b0000, 0, 0, 0, 0, 1, 0, 1);
      check("stk_pop_bottom", 32'(flags_q), 32'h5);
      check("stk_empty", 32'(stack_empty), 32'd1);
      step(1, 4'b0010, 0, 0, 0, 0, 1, 0, 1);
      check("stk_unf_err", 32'(stack_err), 32'd1);
      check("stk_unf_flags", 32'(flags_q), 32'h2);
      step(0, 4'b0000, 0, 0, 0, 0, 1, 1, 0);
      step(0, 4'b0000, 0, 0, 0, 0, 1, 1, 1);
      check("stk_pp_err", 32'(stack_err), 32'd1);
      check("stk_pp_empty", 32'(stack_empty), 32'd0);
      check("stk_pp_full", 32'(stack_full), 32'd0);
`else
      step(0, 4'b0000, 0, 0, 0, 0, 1, 1, 0);
      step(0, 4'b0000, 0, 0, 0, 0, 1, 0, 1);
      check("nostk_err", 32'(stack_err), 32'd0);
      check("nostk_empty", 32'(stack_empty), 32'd1);
      check("nostk_flags", 32'(flags_q), 32'h5);
`endif

      // Random traffic.
      repeat (600) begin
         step(($urandom % 3) == 0, 4'($urandom), ($urandom % 4) != 0, int'($urandom % 16),
              int'($urandom % MODV), int'($urandom % MODV), ($urandom % 4) != 0,
              ($urandom % 8) == 0, ($urandom % 8) == 0);
      end

      // Asynchronous reset with a result pending.
      step(1, 4'b1111, 1, 0, 'h30, 'h01, 0, 0, 0);
      drive_idle();
      check("pre_rst_valid", 32'(res_valid), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("arst_res_valid", 32'(res_valid), 32'd0);
      check("arst_flags_q", 32'(flags_q), 32'd0);
      check("arst_stack_empty", 32'(stack_empty), 32'd1);
      reset_model();
      @(negedge clk);
      rst_n = 1'b1;

      repeat (100) begin
         step(($urandom % 3) == 0, 4'($urandom), ($urandom % 4) != 0, int'($urandom % 16),
              int'($urandom % MODV), int'($urandom % MODV), ($urandom % 4) != 0,
              ($urandom % 8) == 0, ($urandom % 8) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
